// File: rtl/pool_seq_ctrl_if.sv
// Bus bundle between the max-pool sequencer and its surroundings (layer
// controller, feature-map SRAM, pooling unit and output buffer).
interface pool_seq_ctrl_if #(
  parameter int ADDR_W = 10
) ();
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              pool_en;
  logic              pool_first;
  logic              pool_last;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  modport master (
    input  start, abort,
    output busy, done, rd_en, rd_addr, pool_en, pool_first, pool_last,
           wr_en, wr_addr
  );

  modport slave (
    output start, abort,
    input  busy, done, rd_en, rd_addr, pool_en, pool_first, pool_last,
           wr_en, wr_addr
  );
endinterface

// File: rtl/pool_seq_ctrl.sv
// Max-pool window sequencer: one SRAM read per cycle in POOL x POOL windows,
// pooling strobes, delayed output-buffer writes. Optional POOL_SEQ_PERF_EN adds perf_cycles.
module pool_seq_ctrl #(
  parameter int MAP_W  = 28,
  parameter int MAP_H  = 28,
  parameter int POOL   = 2,
  parameter int ADDR_W = 10,
  parameter int WR_DLY = 2   // must be >= 1
) (
  input  logic            clk,
  input  logic            rst,
  pool_seq_ctrl_if.master bus
`ifdef POOL_SEQ_PERF_EN
  ,
  output logic [31:0]     perf_cycles
`endif
);

  localparam int OW   = MAP_W / POOL;
  localparam int OH   = MAP_H / POOL;
  localparam int DC_W = $clog2(WR_DLY + 1);

  localparam logic [ADDR_W-1:0] A_ZERO    = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] POOL_M1   = ADDR_W'(POOL - 1);
  localparam logic [ADDR_W-1:0] OW_M1     = ADDR_W'(OW - 1);
  localparam logic [ADDR_W-1:0] OH_M1     = ADDR_W'(OH - 1);
  localparam logic [ADDR_W-1:0] STEP_COL  = ADDR_W'(POOL);
  localparam logic [ADDR_W-1:0] STEP_ROW  = ADDR_W'(MAP_W);
  localparam logic [ADDR_W-1:0] STEP_OROW = ADDR_W'(POOL * MAP_W);
  localparam logic [DC_W-1:0]   DC_ONE    = DC_W'(1);
  localparam logic [DC_W-1:0]   DC_LAST   = DC_W'(WR_DLY);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  state_t state_r, state_s;

  logic [ADDR_W-1:0] wc_r, wr_r, ocol_r, orow_r;
  logic [ADDR_W-1:0] wc_s, wr_s, ocol_s, orow_s;
  logic [ADDR_W-1:0] orow_base_r, win_base_r, line_base_r, rd_addr_r;
  logic [ADDR_W-1:0] orow_base_s, win_base_s, line_base_s, rd_addr_s;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DC_W-1:0]   drain_cnt_r;
  logic [WR_DLY-1:0] pl_pipe_r, pl_pipe_s;
  logic              last_elem_s;

  logic busy_r, done_r, rd_en_r, pool_en_r, pool_first_r, pool_last_r;
  logic busy_s, done_s, rd_en_s, pool_en_s, pool_first_s, pool_last_s;

  assign last_elem_s = (wc_r == POOL_M1) && (wr_r == POOL_M1) &&
                       (ocol_r == OW_M1) && (orow_r == OH_M1);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; abort beats start in IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.abort)      state_s = S_IDLE;
        else if (bus.start) state_s = S_RUN;
        else                state_s = S_IDLE;
      end
      S_RUN: begin
        if (bus.abort)        state_s = S_IDLE;
        else if (last_elem_s) state_s = S_DRAIN;
        else                  state_s = S_RUN;
      end
      S_DRAIN: begin
        if (bus.abort)                   state_s = S_IDLE;
        else if (drain_cnt_r == DC_LAST) state_s = S_DONE;
        else                             state_s = S_DRAIN;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Next window position and read address; purely incremental, no multiply
  always_comb begin
    wc_s        = wc_r;
    wr_s        = wr_r;
    ocol_s      = ocol_r;
    orow_s      = orow_r;
    orow_base_s = orow_base_r;
    win_base_s  = win_base_r;
    line_base_s = line_base_r;
    rd_addr_s   = rd_addr_r;
    if (state_r == S_IDLE) begin
      wc_s        = A_ZERO;
      wr_s        = A_ZERO;
      ocol_s      = A_ZERO;
      orow_s      = A_ZERO;
      orow_base_s = A_ZERO;
      win_base_s  = A_ZERO;
      line_base_s = A_ZERO;
      rd_addr_s   = A_ZERO;
    end else if (wc_r != POOL_M1) begin
      wc_s      = wc_r + A_ONE;
      rd_addr_s = rd_addr_r + A_ONE;
    end else if (wr_r != POOL_M1) begin
      wc_s        = A_ZERO;
      wr_s        = wr_r + A_ONE;
      line_base_s = line_base_r + STEP_ROW;
      rd_addr_s   = line_base_s;
    end else if (ocol_r != OW_M1) begin
      wc_s        = A_ZERO;
      wr_s        = A_ZERO;
      ocol_s      = ocol_r + A_ONE;
      win_base_s  = win_base_r + STEP_COL;
      line_base_s = win_base_s;
      rd_addr_s   = win_base_s;
    end else if (orow_r != OH_M1) begin
      wc_s        = A_ZERO;
      wr_s        = A_ZERO;
      ocol_s      = A_ZERO;
      orow_s      = orow_r + A_ONE;
      orow_base_s = orow_base_r + STEP_OROW;
      win_base_s  = orow_base_s;
      line_base_s = orow_base_s;
      rd_addr_s   = orow_base_s;
    end else begin
      rd_addr_s = rd_addr_r;
    end
  end

  // FSM output decode: next value of every registered strobe
  always_comb begin
    busy_s       = 1'b0;
    done_s       = 1'b0;
    rd_en_s      = 1'b0;
    pool_en_s    = 1'b0;
    pool_first_s = 1'b0;
    pool_last_s  = 1'b0;
    case (state_s)
      S_IDLE: begin
        busy_s = 1'b0;
      end
      S_RUN: begin
        busy_s       = 1'b1;
        rd_en_s      = 1'b1;
        pool_en_s    = 1'b1;
        pool_first_s = (wc_s == A_ZERO) && (wr_s == A_ZERO);
        pool_last_s  = (wc_s == POOL_M1) && (wr_s == POOL_M1);
      end
      S_DRAIN: begin
        busy_s    = 1'b1;
        pool_en_s = 1'b1;
      end
      S_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Output strobe registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      rd_en_r      <= 1'b0;
      pool_en_r    <= 1'b0;
      pool_first_r <= 1'b0;
      pool_last_r  <= 1'b0;
    end else begin
      busy_r       <= busy_s;
      done_r       <= done_s;
      rd_en_r      <= rd_en_s;
      pool_en_r    <= pool_en_s;
      pool_first_r <= pool_first_s;
      pool_last_r  <= pool_last_s;
    end
  end

  // Window counters and address bases; cleared whenever the sequencer idles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wc_r        <= A_ZERO;
      wr_r        <= A_ZERO;
      ocol_r      <= A_ZERO;
      orow_r      <= A_ZERO;
      orow_base_r <= A_ZERO;
      win_base_r  <= A_ZERO;
      line_base_r <= A_ZERO;
      rd_addr_r   <= A_ZERO;
    end else if (state_s == S_RUN) begin
      wc_r        <= wc_s;
      wr_r        <= wr_s;
      ocol_r      <= ocol_s;
      orow_r      <= orow_s;
      orow_base_r <= orow_base_s;
      win_base_r  <= win_base_s;
      line_base_r <= line_base_s;
      rd_addr_r   <= rd_addr_s;
    end else if (state_s == S_IDLE) begin
      wc_r        <= A_ZERO;
      wr_r        <= A_ZERO;
      ocol_r      <= A_ZERO;
      orow_r      <= A_ZERO;
      orow_base_r <= A_ZERO;
      win_base_r  <= A_ZERO;
      line_base_r <= A_ZERO;
      rd_addr_r   <= A_ZERO;
    end else begin
      rd_addr_r <= rd_addr_r;
    end
  end

  // DRAIN lasts WR_DLY cycles: the last one carries the final write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt_r <= {DC_W{1'b0}};
    end else if (state_r == S_RUN) begin
      drain_cnt_r <= DC_ONE;
    end else if (state_r == S_DRAIN) begin
      drain_cnt_r <= drain_cnt_r + DC_ONE;
    end else begin
      drain_cnt_r <= {DC_W{1'b0}};
    end
  end

  // pool_last delay line; its last tap is the write strobe
  always_comb begin
    pl_pipe_s    = pl_pipe_r;
    pl_pipe_s[0] = pool_last_r;
    for (int i = 1; i < WR_DLY; i++) begin
      pl_pipe_s[i] = pl_pipe_r[i-1];
    end
  end

  // Returning to IDLE (abort included) flushes pending writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pl_pipe_r <= {WR_DLY{1'b0}};
    end else if (state_s == S_IDLE) begin
      pl_pipe_r <= {WR_DLY{1'b0}};
    end else begin
      pl_pipe_r <= pl_pipe_s;
    end
  end

  // Output-buffer address: restarts with each accepted frame, steps after each write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_r <= A_ZERO;
    end else if ((state_r == S_IDLE) && (state_s == S_RUN)) begin
      wr_addr_r <= A_ZERO;
    end else if (pl_pipe_r[WR_DLY-1]) begin
      wr_addr_r <= wr_addr_r + A_ONE;
    end else begin
      wr_addr_r <= wr_addr_r;
    end
  end

`ifdef POOL_SEQ_PERF_EN
  // Busy-cycle counter: cleared on accepted start, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= 32'd0;
    end else if ((state_r == S_IDLE) && (state_s == S_RUN)) begin
      perf_cycles <= 32'd0;
    end else if (busy_r && (perf_cycles != {32{1'b1}})) begin
      perf_cycles <= perf_cycles + 32'd1;
    end else begin
      perf_cycles <= perf_cycles;
    end
  end
`endif

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.rd_en      = rd_en_r;
  assign bus.rd_addr    = rd_addr_r;
  assign bus.pool_en    = pool_en_r;
  assign bus.pool_first = pool_first_r;
  assign bus.pool_last  = pool_last_r;
  assign bus.wr_en      = pl_pipe_r[WR_DLY-1];
  assign bus.wr_addr    = wr_addr_r;

endmodule
